fifo_stream_reader: RTL
=======================

// Module: fifo_stream_reader
// PURPOSE
//   Read-side master for the 8-bit synchronous FIFO. Pops the FIFO via its rd/empty/data_out
//   interface, absorbs the FIFO's one-cycle registered read latency in a small credit-managed
//   buffer, and presents a valid/ready byte stream with packet framing (out_last).
//   Sits between the FIFO and any downstream stream consumer (e.g. serializer, DMA sink).
// PARAMETERS
//   DATA_W     8   width of FIFO data and stream data
//   BUF_DEPTH  3   local buffer entries; >=3 required for 1 beat/cycle sustained throughput
//   PKT_LEN    8   beats per packet; out_last marks the PKT_LEN-th beat
// PORTS
//   clk         in   1                  single clock, all logic on posedge
//   rst         in   1                  asynchronous, active-low reset
//   en          in   1                  1 = issue FIFO reads; 0 = stop issuing, still drain
//   fifo_empty  in   1                  FIFO empty flag
//   fifo_rd     out  1                  FIFO read strobe
//   fifo_data   in   DATA_W             FIFO data_out; valid the cycle after an accepted fifo_rd
//   out_data    out  DATA_W             stream data (head of buffer)
//   out_valid   out  1                  stream valid
//   out_ready   in   1                  stream ready; beat transfers when out_valid && out_ready
//   out_last    out  1                  high with the last beat of each PKT_LEN packet
//   buf_cnt     out  $clog2(BUF_DEPTH+1) entries currently held in buffer
// BEHAVIOUR
//   - Reset (rst=0, async, no clock needed): out_valid=0, out_data=0, out_last=0, buf_cnt=0,
//     fifo_rd=0, inflight=0, beat index=0, buffer pointers=0. In-flight read data discarded.
//   - fifo_rd = en && !fifo_empty && !rst_active && (buf_cnt + inflight < BUF_DEPTH).
//     Depends on registered state only; no combinational path from out_ready to fifo_rd.
//   - fifo_rd is never asserted while fifo_empty=1 (FIFO pointer integrity depends on it).
//   - inflight <= fifo_rd each cycle. When inflight=1, fifo_data is written to buffer tail.
//   - Latency: first out_valid rises 2 cycles after the first fifo_rd (read, capture, present).
//   - Pop when out_valid && out_ready. Push and pop in the same cycle: buf_cnt unchanged,
//     both pointers advance. Pointers wrap modulo BUF_DEPTH (non-power-of-2 handled explicitly).
//   - out_valid = (buf_cnt != 0); out_data/out_last stable while out_valid && !out_ready.
//   - Beat index counts 0..PKT_LEN-1 on each transfer, wraps to 0 after PKT_LEN-1;
//     out_last = out_valid && (beat index == PKT_LEN-1). Index advances only on transfer.
//   - Credit rule guarantees no overflow: buf_cnt never exceeds BUF_DEPTH, capture never dropped.
//   - en=0 mid-stream: no new fifo_rd next cycle; outstanding inflight still captured;
//     buffer drains normally; beat index retained (packet resumes when en returns).
//   - Order preserved strictly: out_data sequence equals FIFO pop sequence.
// STRUCTURE
//   - Shared package fifo_pkg: DATA_W default, BUF_DEPTH default, PKT_LEN default,
//     clog2 helper function for counter/pointer widths.
//   - One sub-module: stream_skid_buf (BUF_DEPTH-entry circular buffer, push/pop, count, head).
//   - Top holds credit/inflight logic, fifo_rd generation, beat/packet counter.
// TESTING
//   1 Assert rst=0 asynchronously mid-cycle -> out_valid, fifo_rd, out_last, buf_cnt = 0 at once.
//   2 FIFO preloaded 0x10..0x17, en=1, out_ready=1 -> fifo_rd high 8 consecutive cycles;
//     out_data 0x10..0x17 on 8 consecutive cycles starting 2 cycles after first fifo_rd;
//     out_last only with 0x17.
//   3 FIFO holds 8 bytes, out_ready=0 -> exactly 3 fifo_rd pulses, buf_cnt=3, then fifo_rd=0;
//     raise out_ready -> remaining bytes follow in order, none lost or duplicated.
//   4 fifo_empty=1 for 20 cycles with en=1 -> fifo_rd never asserted, out_valid=0.
//   5 Stream 20 bytes, drop en after byte 5 is read -> at most the in-flight byte plus
//     buffered bytes emitted, no new fifo_rd; re-raise en -> byte 6 onward, out_last on
//     beats 8 and 16.
//   6 Random out_ready (50%) over 200 bytes vs scoreboard -> exact order, buf_cnt<=3 always,
//     fifo_rd never with fifo_empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and width helpers for the FIFO stream reader
package fifo_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int BUF_DEPTH_DEF = 3;
  localparam int PKT_LEN_DEF   = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  // Zero-width vectors are illegal, so depth-1 counters still get one bit.
  function automatic int width_of(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - DEPTH-entry circular buffer with push/pop, occupancy and head output
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = BUF_DEPTH_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic [DATA_W-1:0]            i_push_data,
  input  logic                         i_pop,
  output logic [DATA_W-1:0]            o_head,
  output logic                         o_valid,
  output logic [width_of(DEPTH+1)-1:0] o_cnt
);

  localparam int PTR_W = width_of(DEPTH);
  localparam int CNT_W = width_of(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_pop;

  // DEPTH need not be a power of two, so wrap is an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop   = i_pop && (r_cnt != '0);
  assign o_valid = (r_cnt != '0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_cnt   = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read master with credit-managed buffer and packet-framed stream output
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int PKT_LEN   = PKT_LEN_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             fifo_empty,
  output logic                             fifo_rd,
  input  logic [DATA_W-1:0]                fifo_data,
  output logic [DATA_W-1:0]                out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic [width_of(BUF_DEPTH+1)-1:0] buf_cnt
);

  localparam int IDX_W = width_of(PKT_LEN);

  logic             r_inflight;
  logic [IDX_W-1:0] r_beat_idx;
  logic             w_credit_ok;
  logic             w_xfer;

  // A read in flight already owns a buffer slot, so it counts against credit.
  assign w_credit_ok = (int'(buf_cnt) + int'(r_inflight)) < BUF_DEPTH;
  assign fifo_rd     = rst && en && !fifo_empty && w_credit_ok;
  assign w_xfer      = out_valid && out_ready;
  assign out_last    = out_valid && (r_beat_idx == IDX_W'(PKT_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= 1'b0;
      r_beat_idx <= '0;
    end else begin
      r_inflight <= fifo_rd;
      if (w_xfer) begin
        r_beat_idx <= (r_beat_idx == IDX_W'(PKT_LEN - 1)) ? '0 : r_beat_idx + IDX_W'(1);
      end
    end
  end

  stream_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_push      (r_inflight),
    .i_push_data (fifo_data),
    .i_pop       (w_xfer),
    .o_head      (out_data),
    .o_valid     (out_valid),
    .o_cnt       (buf_cnt)
  );

endmodule
